// File: rtl/vdp_pkg.sv
// Shared constants, encodings and helpers for the VDP CPU port interface.
package vdp_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_IDX_W = 3;

  // VDP register indices
  localparam logic [REG_IDX_W-1:0] R0 = 3'd0;
  localparam logic [REG_IDX_W-1:0] R1 = 3'd1;
  localparam logic [REG_IDX_W-1:0] R2 = 3'd2;
  localparam logic [REG_IDX_W-1:0] R3 = 3'd3;
  localparam logic [REG_IDX_W-1:0] R4 = 3'd4;
  localparam logic [REG_IDX_W-1:0] R5 = 3'd5;
  localparam logic [REG_IDX_W-1:0] R6 = 3'd6;
  localparam logic [REG_IDX_W-1:0] R7 = 3'd7;

  // Status register: frame flag position
  localparam int unsigned STAT_F = 7;

  // Second control byte codes in cpu_din[7:6]; any code with bit 7 set is a register write
  localparam logic [1:0] CTRL_RD_SETUP = 2'b00;
  localparam logic [1:0] CTRL_WR_SETUP = 2'b01;
  localparam logic       CTRL_REG_MSB  = 1'b1;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_G1   = 2'd1,
    MODE_G2   = 2'd2,
    MODE_MC   = 2'd3
  } vdp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_VRAM = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_CAP  = 2'd3
  } vdp_state_e;

  // Mode bits resolve by priority M1 > M3 > M2; none set means graphics I
  function automatic vdp_mode_e decode_mode(input logic m1, input logic m2, input logic m3);
    if (m1)      return MODE_TEXT;
    else if (m3) return MODE_G2;
    else if (m2) return MODE_MC;
    else         return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_int_sync.sv
// Synchroniser and falling-edge detector for the video stage's frame pulse.
module vdp_int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_n_int,
  output logic o_fall_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the active-low pulse through the synchroniser; idle level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= i_n_int;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse on the high-to-low transition of the synchronised signal
  assign o_fall_c = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/vdp_port_if.sv
// TMS9918-style CPU port: register file, VRAM pointer, read-ahead buffer and frame interrupt.
module vdp_port_if
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_a0,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_din,
  input  logic [7:0]        vram_dout,
  output logic              vram_wr,
  output logic              vram_rd,
  input  logic              n_int_in,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] name_table_addr,
  output logic [ADDR_W-1:0] font_addr,
  output logic [ADDR_W-1:0] color_table_addr,
  output logic [7:0]        backdrop,
  output logic              video_on,
  output logic              n_int
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rbuf;
  logic [DATA_W-1:0] r_lat;
  logic [DATA_W-1:0] r_wdata;
  logic              r_latch_tog;
  logic              r_flag;
  vdp_state_e        r_state;
  vdp_state_e        w_state_nxt;

  logic              w_data_wr;
  logic              w_data_rd;
  logic              w_ctrl_wr;
  logic              w_ctrl_rd;
  logic              w_ctrl_second;
  logic              w_reg_wr;
  logic              w_addr_set;
  logic              w_rd_setup;
  logic              w_int_fall;
  logic [DATA_W-1:0] w_status;
  vdp_mode_e         w_mode;

  // Strobe decode by port
  assign w_data_wr     = cpu_wr & ~cpu_a0;
  assign w_data_rd     = cpu_rd & ~cpu_a0;
  assign w_ctrl_wr     = cpu_wr &  cpu_a0;
  assign w_ctrl_rd     = cpu_rd &  cpu_a0;
  assign w_ctrl_second = w_ctrl_wr & r_latch_tog;
  assign w_reg_wr      = w_ctrl_second & (cpu_din[7] == CTRL_REG_MSB);
  assign w_addr_set    = w_ctrl_second & (cpu_din[7] != CTRL_REG_MSB);
  assign w_rd_setup    = w_ctrl_second & (cpu_din[7:6] == CTRL_RD_SETUP);

  vdp_int_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk      (clk),
    .reset    (reset),
    .i_n_int  (n_int_in),
    .o_fall_c (w_int_fall)
  );

  // VRAM access sequencer state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // VRAM access sequencer: next state and strobes decoded from the current state
  always_comb begin
    w_state_nxt = r_state;
    vram_wr     = 1'b0;
    vram_rd     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_data_wr)                   w_state_nxt = ST_WR_VRAM;
        else if (w_data_rd | w_rd_setup) w_state_nxt = ST_RD_REQ;
      end
      ST_WR_VRAM: begin
        vram_wr     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RD_REQ: begin
        vram_rd     = 1'b1;
        w_state_nxt = ST_RD_CAP;
      end
      ST_RD_CAP: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // VRAM pointer: loaded by address setup, advanced after each completed access
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_addr_set) begin
      r_addr <= ADDR_W'({cpu_din[5:0], r_lat});
    end else if ((r_state == ST_WR_VRAM) || (r_state == ST_RD_CAP)) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Read-ahead buffer and write data holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rbuf  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_data_wr) begin
        r_rbuf  <= cpu_din;
        r_wdata <= cpu_din;
      end else if (r_state == ST_RD_CAP) begin
        r_rbuf  <= vram_dout;
      end
    end
  end

  // Two-byte control latch; any other port access resynchronises the byte order
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat       <= '0;
      r_latch_tog <= 1'b0;
    end else if (w_ctrl_wr) begin
      if (!r_latch_tog) begin
        r_lat       <= cpu_din;
        r_latch_tog <= 1'b1;
      end else begin
        r_latch_tog <= 1'b0;
      end
    end else if (w_data_wr | w_data_rd | w_ctrl_rd) begin
      r_latch_tog <= 1'b0;
    end
  end

  // Register file R0..R7, written from the latched first control byte
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_wr) begin
      r_regs[cpu_din[REG_IDX_W-1:0]] <= r_lat;
    end
  end

  // Frame flag: a new frame edge beats a same-cycle status read clear
  always_ff @(posedge clk) begin
    if (reset)           r_flag <= 1'b0;
    else if (w_int_fall) r_flag <= 1'b1;
    else if (w_ctrl_rd)  r_flag <= 1'b0;
  end

  // CPU read mux, valid during the read strobe only
  always_comb begin
    w_status         = '0;
    w_status[STAT_F] = r_flag;
    cpu_dout         = '0;
    if (w_data_rd)      cpu_dout = r_rbuf;
    else if (w_ctrl_rd) cpu_dout = w_status;
  end

  // Video stage configuration derived from the register file
  assign w_mode           = decode_mode(r_regs[R1][4], r_regs[R1][3], r_regs[R0][1]);
  assign mode             = w_mode;
  assign name_table_addr  = ADDR_W'({r_regs[R2][3:0], 10'b0});
  assign font_addr        = ADDR_W'({r_regs[R4][2:0], 11'b0});
  assign color_table_addr = ADDR_W'({r_regs[R3], 6'b0});
  assign backdrop         = r_regs[R7];
  assign video_on         = r_regs[R1][6];
  assign n_int            = ~(r_flag & r_regs[R1][5]);

  // VRAM port address and write data
  assign vram_addr = r_addr;
  assign vram_din  = r_wdata;

endmodule
